// File: rtl/pc_ras_if.sv
// Fetch-control bundle for pc_ras.
// master : fetch controller, drives the sequencing commands and reads PC/RAS status.
// slave  : pc_ras, consumes the commands and reports pc_cnt, ras_level and the
//          ras_full/ras_empty/ras_ovf/ras_unf status bits.
// Commands : stall, en_cnt, en_offset, pc_offset (signed), en_jump, en_call,
//            en_ret, jump_addr, err_clr.
interface pc_ras_if #(
   parameter int WIDTH     = 16,
   parameter int RAS_DEPTH = 4
) ();
   localparam int LVL_W = $clog2(RAS_DEPTH + 1);

   logic                    stall;
   logic                    en_cnt;
   logic                    en_offset;
   logic signed [WIDTH-1:0] pc_offset;
   logic                    en_jump;
   logic                    en_call;
   logic                    en_ret;
   logic        [WIDTH-1:0] jump_addr;
   logic                    err_clr;

   logic        [WIDTH-1:0] pc_cnt;
   logic        [LVL_W-1:0] ras_level;
   logic                    ras_full;
   logic                    ras_empty;
   logic                    ras_ovf;
   logic                    ras_unf;

   modport master (
      output stall, en_cnt, en_offset, pc_offset, en_jump, en_call, en_ret,
             jump_addr, err_clr,
      input  pc_cnt, ras_level, ras_full, ras_empty, ras_ovf, ras_unf
   );

   modport slave (
      input  stall, en_cnt, en_offset, pc_offset, en_jump, en_call, en_ret,
             jump_addr, err_clr,
      output pc_cnt, ras_level, ras_full, ras_empty, ras_ovf, ras_unf
   );
endinterface

// File: rtl/pc_ras.sv
// Fetch-stage program counter with relative branch, absolute jump, call/return
// and a circular return-address stack.
// Ports:
//   clock : rising-edge clock
//   reset : asynchronous, active-high; pc_cnt <= RESET_VEC, RAS emptied, flags cleared
//   bus   : pc_ras_if.slave, carrying the sequencing commands in and the
//           pc_cnt / RAS status out
// Per-cycle priority: stall > en_ret > en_call > en_jump > en_offset > en_cnt > hold.
// All PC arithmetic wraps modulo 2^WIDTH.
module pc_ras #(
   parameter int                  WIDTH     = 16,
   parameter int                  RAS_DEPTH = 4,
   parameter logic [WIDTH-1:0]    RESET_VEC = '0,
   parameter int unsigned         STEP      = 1
) (
   input  logic    clock,
   input  logic    reset,
   pc_ras_if.slave bus
);
   localparam int LVL_W = $clog2(RAS_DEPTH + 1);
   localparam int PTR_W = $clog2(RAS_DEPTH);
   localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);
   localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(RAS_DEPTH);

   logic [WIDTH-1:0] pc_q, pc_d;
   logic [WIDTH-1:0] stack [RAS_DEPTH];
   logic [PTR_W-1:0] ptr_q, ptr_d;   // slot the next push writes
   logic [LVL_W-1:0] lvl_q, lvl_d;
   logic             ovf_q, unf_q;
   logic             push;
   logic             set_ovf, set_unf;
   logic [PTR_W-1:0] top_idx;
   logic [WIDTH-1:0] seq_pc;
   logic             full, empty;

   function automatic logic [WIDTH-1:0] add_mod(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
      return a + b;
   endfunction

   // Signed offset added in two's complement; the sum wraps at 2^WIDTH.
   function automatic logic [WIDTH-1:0] add_offset(input logic        [WIDTH-1:0] pc,
                                                   input logic signed [WIDTH-1:0] off);
      return pc + $unsigned(off);
   endfunction

   // Explicit wrap so RAS_DEPTH need not be a power of two.
   function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(RAS_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   function automatic logic [PTR_W-1:0] ptr_prev(input logic [PTR_W-1:0] p);
      return (p == '0) ? PTR_W'(RAS_DEPTH - 1) : p - 1'b1;
   endfunction

   assign top_idx = ptr_prev(ptr_q);
   assign seq_pc  = add_mod(pc_q, STEP_W);
   assign full    = (lvl_q == LVL_FULL);
   assign empty   = (lvl_q == '0);

   always_comb begin
      pc_d    = pc_q;
      ptr_d   = ptr_q;
      lvl_d   = lvl_q;
      push    = 1'b0;
      set_ovf = 1'b0;
      set_unf = 1'b0;
      if (!bus.stall) begin
         if (bus.en_ret) begin
            if (empty) begin
               // Underflow: fall through sequentially, stack untouched.
               pc_d    = seq_pc;
               set_unf = 1'b1;
            end else begin
               pc_d  = stack[top_idx];
               ptr_d = top_idx;
               lvl_d = lvl_q - 1'b1;
            end
         end else if (bus.en_call) begin
            // When full, ptr_q already points at the oldest entry, so the
            // push overwrites it and the level saturates.
            push  = 1'b1;
            pc_d  = bus.jump_addr;
            ptr_d = ptr_next(ptr_q);
            if (full) set_ovf = 1'b1;
            else      lvl_d   = lvl_q + 1'b1;
         end else if (bus.en_jump) begin
            pc_d = bus.jump_addr;
         end else if (bus.en_offset) begin
            pc_d = add_offset(pc_q, bus.pc_offset);
         end else if (bus.en_cnt) begin
            pc_d = seq_pc;
         end
      end
   end

   // ---- control registers ----
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         pc_q  <= RESET_VEC;
         ptr_q <= '0;
         lvl_q <= '0;
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
      end else begin
         pc_q  <= pc_d;
         ptr_q <= ptr_d;
         lvl_q <= lvl_d;
         // err_clr acts even under stall; a flag being set this cycle wins.
         ovf_q <= set_ovf | (ovf_q & ~bus.err_clr);
         unf_q <= set_unf | (unf_q & ~bus.err_clr);
      end
   end

   // ---- stack storage (contents are don't-care after reset) ----
   always_ff @(posedge clock) begin
      if (push) stack[ptr_q] <= seq_pc;
   end

   assign bus.pc_cnt    = pc_q;
   assign bus.ras_level = lvl_q;
   assign bus.ras_full  = full;
   assign bus.ras_empty = empty;
   assign bus.ras_ovf   = ovf_q;
   assign bus.ras_unf   = unf_q;
endmodule

// File: tb/tb_pc_ras.sv
module tb_pc_ras;
   localparam int W = 16;
   localparam int D = 4;

   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   pc_ras_if #(.WIDTH(W), .RAS_DEPTH(D)) bus ();

   pc_ras #(.WIDTH(W), .RAS_DEPTH(D), .RESET_VEC(16'h0000), .STEP(1)) dut (
      .clock(clock),
      .reset(reset),
      .bus  (bus)
   );

   int errors = 0;
   int checks = 0;

   typedef struct packed {
      logic        st, rt, cl, jp, of, cn;
      logic [15:0] off;
      logic [15:0] ja;
      logic [15:0] pc;
      logic [2:0]  lvl;
   } vec_t;

   vec_t tbl [20];

   // Reference model: the stack is a plain queue of return addresses.
   int m_pc;
   int q[$];
   bit m_ovf, m_unf;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic chk_state(input string tag, input int pc, input int lvl,
                            input bit ovf, input bit unf);
      chk({tag, " pc_cnt"},    32'(bus.pc_cnt),    32'(pc));
      chk({tag, " ras_level"}, 32'(bus.ras_level), 32'(lvl));
      chk({tag, " ras_full"},  32'(bus.ras_full),  32'(lvl == D));
      chk({tag, " ras_empty"}, 32'(bus.ras_empty), 32'(lvl == 0));
      chk({tag, " ras_ovf"},   32'(bus.ras_ovf),   32'(ovf));
      chk({tag, " ras_unf"},   32'(bus.ras_unf),   32'(unf));
   endtask

   task automatic drive(input logic st, rt, cl, jp, of, cn, ec,
                        input logic [15:0] off, input logic [15:0] ja);
      bus.stall     = st;
      bus.en_ret    = rt;
      bus.en_call   = cl;
      bus.en_jump   = jp;
      bus.en_offset = of;
      bus.en_cnt    = cn;
      bus.err_clr   = ec;
      bus.pc_offset = off;
      bus.jump_addr = ja;
   endtask

   task automatic idle();
      drive(0, 0, 0, 0, 0, 0, 0, 16'h0, 16'h0);
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // One clock: drive, step the model, compare.
   task automatic rstep(input string tag, input logic st, rt, cl, jp, of, cn, ec,
                        input logic [15:0] off, input logic [15:0] ja);
      bit so, su;
      drive(st, rt, cl, jp, of, cn, ec, off, ja);
      tick();
      so = 0;
      su = 0;
      if (!st) begin
         if (rt) begin
            if (q.size() == 0) begin
               m_pc = (m_pc + 1) % 65536;
               su   = 1;
            end else begin
               m_pc = q.pop_back();
            end
         end else if (cl) begin
            q.push_back((m_pc + 1) % 65536);
            if (q.size() > D) begin
               void'(q.pop_front());
               so = 1;
            end
            m_pc = int'(ja);
         end else if (jp) begin
            m_pc = int'(ja);
         end else if (of) begin
            m_pc = (m_pc + int'($signed(off)) + 65536) % 65536;
         end else if (cn) begin
            m_pc = (m_pc + 1) % 65536;
         end
      end
      m_ovf = so | (m_ovf & !ec);
      m_unf = su | (m_unf & !ec);
      chk_state(tag, m_pc, q.size(), m_ovf, m_unf);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      idle();
      tick();
      tick();
      reset = 1'b0;
      m_pc  = 0;
      q.delete();
      m_ovf = 0;
      m_unf = 0;
   endtask

   initial begin
      //                st rt cl jp of cn   off       ja        pc       lvl
      tbl[0]  = '{1'b0,1'b0,1'b0,1'b1,1'b0,1'b0, 16'h0000, 16'h0010, 16'h0010, 3'd0};
      tbl[1]  = '{1'b0,1'b0,1'b0,1'b0,1'b1,1'b0, 16'hFFF8, 16'h0000, 16'h0008, 3'd0};
      tbl[2]  = '{1'b0,1'b0,1'b0,1'b1,1'b0,1'b0, 16'h0000, 16'hFFFF, 16'hFFFF, 3'd0};
      tbl[3]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b1, 16'h0000, 16'h0000, 16'h0000, 3'd0};
      tbl[4]  = '{1'b0,1'b0,1'b0,1'b1,1'b0,1'b0, 16'h0000, 16'h0002, 16'h0002, 3'd0};
      tbl[5]  = '{1'b0,1'b0,1'b0,1'b0,1'b1,1'b0, 16'hFFFD, 16'h0000, 16'hFFFF, 3'd0};
      tbl[6]  = '{1'b0,1'b0,1'b0,1'b1,1'b0,1'b0, 16'h0000, 16'h0020, 16'h0020, 3'd0};
      tbl[7]  = '{1'b0,1'b0,1'b1,1'b0,1'b0,1'b0, 16'h0000, 16'h0100, 16'h0100, 3'd1};
      tbl[8]  = '{1'b0,1'b0,1'b1,1'b0,1'b0,1'b0, 16'h0000, 16'h0200, 16'h0200, 3'd2};
      tbl[9]  = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b0, 16'h0000, 16'h0000, 16'h0101, 3'd1};
      tbl[10] = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b0, 16'h0000, 16'h0000, 16'h0021, 3'd0};
      tbl[11] = '{1'b0,1'b0,1'b0,1'b1,1'b0,1'b0, 16'h0000, 16'h0030, 16'h0030, 3'd0};
      tbl[12] = '{1'b0,1'b0,1'b1,1'b0,1'b0,1'b0, 16'h0000, 16'h0400, 16'h0400, 3'd1};
      tbl[13] = '{1'b0,1'b1,1'b1,1'b1,1'b1,1'b1, 16'h0007, 16'h0500, 16'h0031, 3'd0};
      tbl[14] = '{1'b1,1'b1,1'b1,1'b1,1'b1,1'b1, 16'h0007, 16'h0600, 16'h0031, 3'd0};
      tbl[15] = '{1'b0,1'b0,1'b1,1'b1,1'b1,1'b1, 16'h0003, 16'h0080, 16'h0080, 3'd1};
      tbl[16] = '{1'b0,1'b0,1'b0,1'b1,1'b1,1'b1, 16'h0005, 16'h0090, 16'h0090, 3'd1};
      tbl[17] = '{1'b0,1'b0,1'b0,1'b0,1'b1,1'b1, 16'h0010, 16'h0000, 16'h00A0, 3'd1};
      tbl[18] = '{1'b1,1'b1,1'b0,1'b0,1'b0,1'b0, 16'h0000, 16'h0000, 16'h00A0, 3'd1};
      tbl[19] = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b0, 16'h0000, 16'h0000, 16'h0032, 3'd0};

      // Reset state and sequential count, then asynchronous reset mid-run.
      do_reset();
      chk_state("reset", 0, 0, 0, 0);
      for (int i = 1; i <= 3; i++) begin
         drive(0, 0, 0, 0, 0, 1, 0, 16'h0, 16'h0);
         tick();
         chk_state($sformatf("count%0d", i), i, 0, 0, 0);
      end
      idle();
      #2;
      reset = 1'b1;
      #1;
      chk("async reset pc_cnt", 32'(bus.pc_cnt), 32'h0);
      @(posedge clock);
      #1;
      reset = 1'b0;

      // Directed vector table: wrap, call/ret nesting, priority, stall.
      for (int i = 0; i < 20; i++) begin
         drive(tbl[i].st, tbl[i].rt, tbl[i].cl, tbl[i].jp, tbl[i].of, tbl[i].cn, 1'b0,
               tbl[i].off, tbl[i].ja);
         tick();
         chk_state($sformatf("vec%0d", i), int'(tbl[i].pc), int'(tbl[i].lvl), 0, 0);
      end

      // Overflow by a fifth call, LIFO unwind, then underflow.
      drive(0, 0, 0, 1, 0, 0, 0, 16'h0, 16'h0010);
      tick();
      for (int i = 1; i <= 5; i++) begin
         drive(0, 0, 1, 0, 0, 0, 0, 16'h0, 16'((i + 1) * 16));
         tick();
         chk_state($sformatf("ovf call%0d", i), (i + 1) * 16, (i < D) ? i : D, i == 5, 0);
      end
      for (int i = 1; i <= 4; i++) begin
         drive(0, 1, 0, 0, 0, 0, 0, 16'h0, 16'h0);
         tick();
         chk_state($sformatf("unwind ret%0d", i), 16'h51 - (i - 1) * 16, D - i, 1, 0);
      end
      drive(0, 1, 0, 0, 0, 0, 0, 16'h0, 16'h0);
      tick();
      chk_state("underflow ret", 16'h0022, 0, 1, 1);

      // err_clr clears both; err_clr with an overflowing call leaves ovf set.
      drive(0, 0, 0, 0, 0, 0, 1, 16'h0, 16'h0);
      tick();
      chk_state("err_clr", 16'h0022, 0, 0, 0);
      for (int i = 1; i <= 4; i++) begin
         drive(0, 0, 1, 0, 0, 0, 0, 16'h0, 16'(i * 256));
         tick();
      end
      chk_state("refill", 16'h0400, D, 0, 0);
      drive(0, 0, 1, 0, 0, 0, 1, 16'h0, 16'h0500);
      tick();
      chk_state("clr+ovf call", 16'h0500, D, 1, 0);
      drive(1, 0, 1, 0, 0, 0, 1, 16'h0, 16'h0600);
      tick();
      chk_state("stall+err_clr", 16'h0500, D, 0, 0);

      // Randomized traffic against the queue model.
      do_reset();
      for (int i = 0; i < 400; i++) begin
         rstep($sformatf("rand%0d", i),
               ($urandom % 8) == 0, ($urandom % 4) == 0, ($urandom % 4) == 0,
               ($urandom % 6) == 0, ($urandom % 4) == 0, ($urandom % 2) == 0,
               ($urandom % 16) == 0, 16'($urandom), 16'($urandom));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
